onchip_ram_dp: RTL
==================

# onchip_ram_dp

Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports, byte enables, selectable read latency and a built-in clear engine. It replaces the fixed 32-bit × 32768 single-port program/data memory in the Qsys system. Port s1 serves the Nios II data master; port s2 serves the VIP/camera-side master (frame statistics, line buffers). The clear engine fills the array with a constant after reset or on request, holding both ports off via waitrequest.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 15: word-address width; depth = 2^ADDR_WIDTH.
- BYTE_WIDTH, 8: bits per byte-enable lane; lanes NB = DATA_WIDTH/BYTE_WIDTH.
- OUTPUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- CLEAR_ON_RESET, 1: 1 runs the clear engine automatically when reset is released.
- CLEAR_VALUE, 0: DATA_WIDTH-bit word written by the clear engine.
- clk, in, 1: single clock for both ports.
- reset, in, 1: synchronous, active-high.
- s1_address / s2_address, in, ADDR_WIDTH: word address.
- s1_byteenable / s2_byteenable, in, NB: write lane enables; ignored on reads.
- s1_read / s2_read, in, 1: read request.
- s1_write / s2_write, in, 1: write request.
- s1_writedata / s2_writedata, in, DATA_WIDTH: write data.
- s1_readdata / s2_readdata, out, DATA_WIDTH: read data.
- s1_readdatavalid / s2_readdatavalid, out, 1: one-cycle pulse, qualifies readdata.
- s1_waitrequest / s2_waitrequest, out, 1: request not accepted this cycle.
- clear_start, in, 1: single-cycle pulse that starts a runtime clear.
- clear_busy, out, 1: high while the clear engine owns the array.

## Operation
- A request is accepted when (read|write) & ~waitrequest. Both ports are independent; there is no arbitration except on write collisions.
- Writes update only the lanes whose byteenable bit is 1; the other lanes keep their contents.
- If read and write are asserted together on one port, the write is performed. No readdatavalid is generated for that cycle.
- Same-port read of an address written in the same cycle returns old data. A mixed-port read of an address being written returns old data.
- Write collision (both ports write the same address in the same cycle): s1 wins, the s2 write is dropped, and s2 still sees the request as accepted.
- Clear FSM states:
  - IDLE: waitrequest = 0.
  - CLEAR: waitrequest = 1 on both ports, clear_busy = 1. A counter sweeps addresses 0 to 2^ADDR_WIDTH − 1, writing CLEAR_VALUE with all lanes enabled, one word per cycle through port s1's write path.
  - CLEAR → IDLE after the last address is written.
- Transitions into CLEAR:
  - IDLE → CLEAR on clear_start.
  - Exit from reset goes to CLEAR if CLEAR_ON_RESET = 1, otherwise to IDLE.
- clear_start while already in CLEAR is ignored; the counter does not restart.
- Reset mid-clear aborts the sweep. After reset release the sweep restarts at address 0 if CLEAR_ON_RESET = 1; otherwise the array content is undefined-but-stable and the FSM goes to IDLE.
- Reads accepted before a clear_start still return their data and readdatavalid on schedule; the pipeline is not flushed.

## Timing
- Reset values: readdata = 0, readdatavalid = 0, waitrequest = 1, clear_busy = CLEAR_ON_RESET. The counter is 0 and the FSM is in CLEAR or IDLE accordingly.
- Read latency: readdatavalid and readdata appear exactly 1 + OUTPUT_REG cycles after the accept edge. Back-to-back reads sustain one per cycle per port.
- readdata holds its last value between valid pulses.
- Writes are committed at the accept edge; a read accepted on the next cycle returns the new data.
- Clear duration: clear_busy is high for exactly 2^ADDR_WIDTH cycles. Both waitrequests fall on the cycle after the final clear write.
- clear_start sampled in IDLE raises waitrequest on the following cycle. A request presented in the same cycle as clear_start is still accepted.

## Test plan
- Reset, clear, readback (ADDR_WIDTH = 4, CLEAR_ON_RESET = 1, CLEAR_VALUE = 0xA5A5A5A5):
  - Hold reset 3 cycles, then release.
  - waitrequest and clear_busy stay high for exactly 16 cycles, then fall.
  - Reading all 16 addresses on s2 returns 0xA5A5A5A5.
- Byte-lane writes:
  - s1 writes 0x11223344 to address 5 with byteenable = 0xF, then 0xAABBCCDD with byteenable = 0x5.
  - An s2 read of address 5 returns 0x11BB33DD.
- Read latency: with OUTPUT_REG = 0 and then OUTPUT_REG = 1, issue back-to-back reads on s1 of addresses 0–7.
  - readdatavalid pulses 1 (respectively 2) cycles after each accept.
  - 8 consecutive valid pulses with data in address order.
- Write collision and mixed-port read:
  - Same cycle: s1 writes 0x1 and s2 writes 0x2 to address 3, while s2 reads address 3 → that read returns the old value.
  - A subsequent read of address 3 returns 0x1.
- Runtime clear with reset mid-clear:
  - After memory is loaded, pulse clear_start, then assert reset at sweep address 9.
  - After release, the sweep restarts from 0 and takes the full 2^ADDR_WIDTH cycles.
  - A clear_start pulse during the sweep does not extend it.

Source files
------------

// File: rtl/onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports, byte enables,
// 1- or 2-cycle read latency and a clear engine that sweeps a constant into the array.
module onchip_ram_dp #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 15,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    OUTPUT_REG     = 0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            s1_address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] s1_byteenable,
  input  logic                             s1_read,
  input  logic                             s1_write,
  input  logic [DATA_WIDTH-1:0]            s1_writedata,
  output logic [DATA_WIDTH-1:0]            s1_readdata,
  output logic                             s1_readdatavalid,
  output logic                             s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]            s2_address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] s2_byteenable,
  input  logic                             s2_read,
  input  logic                             s2_write,
  input  logic [DATA_WIDTH-1:0]            s2_writedata,
  output logic [DATA_WIDTH-1:0]            s2_readdata,
  output logic                             s2_readdatavalid,
  output logic                             s2_waitrequest,
  input  logic                             clear_start,
  output logic                             clear_busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Handshake: a request is taken on a rising edge when (read | write) is high
  // and waitrequest is low; readdatavalid is a one-cycle pulse qualifying readdata.
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    wait_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clr_we;
  logic                    s1_we, s2_we, s1_re, s2_re;
  logic                    a_we;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [NB-1:0]           a_be;
  logic [DATA_WIDTH-1:0]   a_data;

  logic [1:0]                 v1_q, v2_q;
  logic [1:0][DATA_WIDTH-1:0] d1_q, d2_q;

  assign clr_we = (state_q == S_CLEAR) && !reset;
  assign s1_we  = s1_write & ~wait_q;
  assign s1_re  = s1_read & ~s1_write & ~wait_q;
  assign s2_re  = s2_read & ~s2_write & ~wait_q;
  // On a same-address write collision the s2 write is dropped but still accepted.
  assign s2_we  = s2_write & ~wait_q & ~(s1_we && (s1_address == s2_address));

  // The clear engine borrows port s1's write path.
  assign a_we   = clr_we | s1_we;
  assign a_addr = clr_we ? cnt_q : s1_address;
  assign a_be   = clr_we ? {NB{1'b1}} : s1_byteenable;
  assign a_data = clr_we ? CLEAR_VALUE : s1_writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b1;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_q <= 1'b0;
          busy_q <= 1'b0;
          if (clear_start) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            wait_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // s2 is written before s1 so that s1 takes priority on any overlap.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (s2_we && s2_byteenable[b])
        mem[s2_address][b*BYTE_WIDTH +: BYTE_WIDTH] <= s2_writedata[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (a_we && a_be[b])
        mem[a_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= a_data[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= '0;
      v2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= {s2_re, s1_re};
      if (s1_re) d1_q[0] <= mem[s1_address];
      if (s2_re) d1_q[1] <= mem[s2_address];
      v2_q <= v1_q;
      for (int p = 0; p < 2; p++)
        if (v1_q[p]) d2_q[p] <= d1_q[p];
    end
  end

  assign s1_readdata      = (OUTPUT_REG != 0) ? d2_q[0] : d1_q[0];
  assign s2_readdata      = (OUTPUT_REG != 0) ? d2_q[1] : d1_q[1];
  assign s1_readdatavalid = (OUTPUT_REG != 0) ? v2_q[0] : v1_q[0];
  assign s2_readdatavalid = (OUTPUT_REG != 0) ? v2_q[1] : v1_q[1];
  assign s1_waitrequest   = wait_q;
  assign s2_waitrequest   = wait_q;
  assign clear_busy       = busy_q;

endmodule
